// File: rtl/vec_pkg.sv
// Shared vector-unit types and default widths.
// Used by the vector execute and writeback stages.
package vec_pkg;

  localparam int VEC_DATA_W = 256;
  localparam int VEC_BEAT_W = 64;
  localparam int VEC_FLAG_W = 64;
  localparam int VEC_ADDR_W = 3;
  localparam int VEC_BEATS  = VEC_DATA_W / VEC_BEAT_W;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [VEC_DATA_W-1:0] result;
    logic [VEC_FLAG_W-1:0] flags;
    logic [VEC_ADDR_W-1:0] rd;
    logic                  scalar;
  } vec_result_t;

endpackage

// File: rtl/vec_wb_serializer.sv
// Vector writeback: splits one ALU result into
// register-file beats, then commits the flags.
module vec_wb_serializer
  import vec_pkg::*;
#(
  parameter int DATA_W = VEC_DATA_W,
  parameter int BEAT_W = VEC_BEAT_W,
  parameter int FLAG_W = VEC_FLAG_W,
  parameter int ADDR_W = VEC_ADDR_W,
  localparam int BEATS = DATA_W / BEAT_W,
  localparam int BIW   =
    (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [FLAG_W-1:0] in_flags,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_scalar,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [BIW-1:0]    wr_beat,
  output logic [BEAT_W-1:0] wr_data,
  output logic [FLAG_W-1:0] flags_q,
  output logic              done
);

  wb_state_t         r_state;
  logic [DATA_W-1:0] r_res;
  logic [FLAG_W-1:0] r_flags;
  logic              r_scalar;

  logic              r_in_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [BIW-1:0]    r_wr_beat;
  logic [BEAT_W-1:0] r_wr_data;
  logic [FLAG_W-1:0] r_flags_q;
  logic              r_done;

  logic [BIW-1:0]    w_last;
  logic              w_is_last;
  logic [BIW-1:0]    w_next;
  logic [BEAT_W-1:0] w_next_data;

  // Final beat index and the following beat's payload.
  always_comb begin
    w_last      = r_scalar ? '0 : BIW'(BEATS - 1);
    w_is_last   = (r_wr_beat == w_last);
    w_next      = r_wr_beat + 1'b1;
    w_next_data =
      r_res[int'(w_next) * BEAT_W +: BEAT_W];
  end

  // Accept in IDLE, stream beats in SEND, commit on last.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_res      <= '0;
      r_flags    <= '0;
      r_scalar   <= 1'b0;
      r_in_ready <= 1'b1;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_beat  <= '0;
      r_wr_data  <= '0;
      r_flags_q  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_res      <= in_result;
            r_flags    <= in_flags;
            r_scalar   <= in_scalar;
            r_wr_en    <= 1'b1;
            r_wr_addr  <= in_rd;
            r_wr_beat  <= '0;
            r_wr_data  <= in_result[BEAT_W-1:0];
            r_in_ready <= 1'b0;
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (wr_ready) begin
            if (w_is_last) begin
              r_flags_q  <= r_flags;
              r_done     <= 1'b1;
              r_wr_en    <= 1'b0;
              r_in_ready <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_wr_beat <= w_next;
              r_wr_data <= w_next_data;
            end
          end
        end
        default: begin
          r_wr_en    <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_beat  = r_wr_beat;
  assign wr_data  = r_wr_data;
  assign flags_q  = r_flags_q;
  assign done     = r_done;

endmodule

// File: tb/tb_vec_wb_serializer.sv
// Randomized bench for vec_wb_serializer with a
// queue-of-beats reference model plus directed cases.
module tb_vec_wb_serializer;

  localparam int DW = 256;
  localparam int BW = 64;
  localparam int FW = 64;
  localparam int AW = 3;
  localparam int NB = DW / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_result;
  logic [FW-1:0] in_flags;
  logic [AW-1:0] in_rd;
  logic          in_scalar;
  logic          wr_en;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_beat;
  logic [BW-1:0] wr_data;
  logic [FW-1:0] flags_q;
  logic          done;

  always #5 clk = ~clk;

  vec_wb_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_flags  (in_flags),
    .in_rd     (in_rd),
    .in_scalar (in_scalar),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_beat   (wr_beat),
    .wr_data   (wr_data),
    .flags_q   (flags_q),
    .done      (done)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    beat;
    logic [BW-1:0] data;
  } beat_t;

  beat_t         q[$];
  logic [FW-1:0] m_flags;
  logic [FW-1:0] m_pend;
  logic          m_done;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(string tag,
                     logic [DW-1:0] got,
                     logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Transaction-level model: pending beats drain on
  // wr_ready; flags commit when the last one leaves.
  task automatic model_edge();
    beat_t b;
    int    n;
    if (rst) begin
      q.delete();
      m_flags = '0;
      m_done  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (q.size() != 0) begin
        if (wr_ready) begin
          b = q.pop_front();
          if (q.size() == 0) begin
            m_flags = m_pend;
            m_done  = 1'b1;
          end
        end
      end else if (in_valid) begin
        m_pend = in_flags;
        n = in_scalar ? 1 : NB;
        for (int i = 0; i < n; i++) begin
          b.addr = in_rd;
          b.beat = 2'(i);
          b.data = in_result[i*BW +: BW];
          q.push_back(b);
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", in_ready, q.size() == 0);
    chk("wr_en", wr_en, q.size() != 0);
    if (q.size() != 0) begin
      chk("wr_addr", wr_addr, q[0].addr);
      chk("wr_beat", wr_beat, q[0].beat);
      chk("wr_data", wr_data, q[0].data);
    end
    chk("done", done, m_done);
    chk("flags_q", flags_q, m_flags);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // Step k=2.. until done; wr_ready low for k in
  // [lo,hi]. lat = step index on which done shows.
  task automatic wait_done(input int lo,
                           input int hi,
                           output int lat);
    lat = 21;
    in_valid = 1'b0;
    for (int k = 2; k <= 20; k++) begin
      wr_ready = !(k >= lo && k <= hi);
      step();
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    wr_ready = 1'b1;
  endtask

  task automatic rand_op();
    for (int i = 0; i < DW / 32; i++)
      in_result[i*32 +: 32] = $urandom();
    in_flags  = {$urandom(), $urandom()};
    in_rd     = AW'($urandom_range(0, 7));
    in_scalar = ($urandom_range(0, 3) == 0);
  endtask

  logic [DW-1:0] pat;
  int            lat;
  int            d1;
  int            d2;
  int            nd;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_result = '0;
    in_flags  = '0;
    in_rd     = '0;
    in_scalar = 1'b0;
    wr_ready  = 1'b1;
    m_flags   = '0;
    m_pend    = '0;
    m_done    = 1'b0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_beat", wr_beat, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_flags_q", flags_q, 0);
    chk("rst_done", done, 0);

    // Vector op, no stall
    pat = {4{64'h1234_5678_90AB_CDEF}};
    in_result = pat;
    in_flags  = 64'hA5;
    in_rd     = 3'd5;
    in_scalar = 1'b0;
    in_valid  = 1'b1;
    step();
    chk("vec_b0_data", wr_data, 64'h1234_5678_90AB_CDEF);
    chk("vec_b0_addr", wr_addr, 5);
    wait_done(0, 0, lat);
    chk("vec_latency", lat, 5);
    chk("vec_flags", flags_q, 64'hA5);

    // Scalar op
    in_rd     = 3'd2;
    in_scalar = 1'b1;
    in_flags  = 64'hFEDC_BA98_7654_3210;
    in_valid  = 1'b1;
    step();
    chk("scl_beat", wr_beat, 0);
    chk("scl_data", wr_data, 64'h1234_5678_90AB_CDEF);
    chk("scl_addr", wr_addr, 2);
    wait_done(0, 0, lat);
    chk("scl_latency", lat, 2);
    chk("scl_flags", flags_q, 64'hFEDC_BA98_7654_3210);
    in_scalar = 1'b0;
    step();
    chk("scl_no_more", wr_en, 0);

    // Backpressure for 3 cycles on beat 1
    rand_op();
    in_scalar = 1'b0;
    in_rd     = 3'd3;
    in_valid  = 1'b1;
    step();
    wait_done(3, 5, lat);
    chk("bp_latency", lat, 8);

    // Back-to-back with in_valid held
    rand_op();
    in_scalar = 1'b0;
    in_rd     = 3'd1;
    in_valid  = 1'b1;
    step();
    rand_op();
    in_scalar = 1'b0;
    in_rd     = 3'd6;
    d1 = 0;
    d2 = 0;
    for (int k = 2; k <= 20; k++) begin
      if (k == 7) in_valid = 1'b0;
      step();
      if (k == 6) chk("b2b_addr2", wr_addr, 6);
      if (done === 1'b1) begin
        if (d1 == 0) d1 = k;
        else begin
          d2 = k;
          break;
        end
      end
    end
    chk("b2b_done1", d1, 5);
    chk("b2b_done2", d2, 10);

    // Reset during beat 2
    rand_op();
    in_scalar = 1'b0;
    in_rd     = 3'd4;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("mid_beat2", wr_beat, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_wr_en", wr_en, 0);
    chk("mid_ready", in_ready, 1);
    chk("mid_flags", flags_q, 0);
    chk("mid_done", done, 0);
    rand_op();
    in_scalar = 1'b0;
    in_valid  = 1'b1;
    step();
    wait_done(0, 0, lat);
    chk("mid_after", lat, 5);

    // Ignore in_valid while busy
    rand_op();
    in_scalar = 1'b0;
    in_rd     = 3'd0;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    nd = 0;
    for (int k = 2; k <= 12; k++) begin
      in_valid = (k == 2 || k == 3);
      in_rd    = 3'd7;
      step();
      if (k <= 4) chk("busy_addr", wr_addr, 0);
      if (done === 1'b1) nd++;
    end
    in_valid = 1'b0;
    chk("busy_dones", nd, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      wr_ready = ($urandom_range(0, 3) != 0);
      rand_op();
      step();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    wr_ready = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_wb_serializer.md
Name: vec_wb_serializer

Overview:
- Writeback-side consumer for the 256-bit vector ALU. It accepts one ALU result (result, flags, destination register, scalar flag) through a valid/ready handshake.
- It serializes the result into 64-bit beats on the vector register file write port, honouring write-port backpressure, then commits the 64-bit flags to an architectural flags register.
- Sits between the vector execute stage and the vector register file.

Parameters:
DATA_W, 256, vector result width
BEAT_W, 64, register file write-port width; DATA_W must be a multiple of BEAT_W
FLAG_W, 64, ALU flags width
ADDR_W, 3, destination vector register index width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  ALU result available
in_ready  output  1  block can accept a result
in_result  input  DATA_W  ALU result vector
in_flags  input  FLAG_W  ALU flags
in_rd  input  ADDR_W  destination vector register
in_scalar  input  1  scalar op: only beat 0 (bits BEAT_W-1:0) is written
wr_en  output  1  write beat valid
wr_ready  input  1  register file accepts beat
wr_addr  output  ADDR_W  destination register
wr_beat  output  clog2(DATA_W/BEAT_W)  beat index, 0 = least-significant
wr_data  output  BEAT_W  beat payload
flags_q  output  FLAG_W  committed flags register
done  output  1  one-cycle pulse when an operation fully commits

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high. Reset values: in_ready=1, wr_en=0, wr_addr=0, wr_beat=0, wr_data=0, flags_q=0, done=0, state=IDLE.
- Beat count: BEATS = DATA_W/BEAT_W (4 by default). Last beat is BEATS-1, or 0 when the latched scalar flag is 1.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready at an edge, latch result, flags, rd and scalar; set beat counter to 0; go to SEND.
  - in_valid while in IDLE is the only accept path.
- SEND:
  - in_ready=0; wr_en=1; wr_data = latched result[beat*BEAT_W +: BEAT_W]; wr_addr = latched rd; wr_beat = counter.
  - Outputs are stable while wr_ready=0. Beat 0 appears the cycle after acceptance.
  - On wr_en&&wr_ready at a non-last beat, the counter increments.
  - On the last beat: flags_q <= latched flags, done=1 the next cycle, go to IDLE. in_ready is 1 in that same next cycle.
- Minimum latency with wr_ready tied 1:
  - Vector: accept at edge N, beats at N+1..N+4, done and flags_q visible at N+5.
  - Scalar: done at N+2.
  - Throughput is one op per BEATS+1 cycles; a new accept is possible in the cycle done is high.
- Scalar mode: exactly one beat with wr_beat=0. Upper bits are never written. Flags are committed in full (FLAG_W bits).
- wr_ready held low indefinitely: the block stalls in SEND with constant outputs. in_valid is ignored and no upstream data is lost, because in_ready=0.
- Counter never wraps past BEATS-1; the transition to IDLE occurs first.
- rst asserted mid-SEND: the transfer is abandoned, flags_q=0, done is not pulsed, and the block returns to IDLE. Beats already written stay in the register file (no rollback).
- done is high for exactly one cycle per committed op and never asserted under reset.

Decomposition:
- Shared package vec_pkg:
  - DATA_W, BEAT_W, FLAG_W and ADDR_W defaults.
  - BEATS constant.
  - ALU opcode enum (3-bit).
  - wb_state_t enum {IDLE, SEND}.
  - Packed struct vec_result_t {result, flags, rd, scalar} reused by the execute stage.
- No sub-module required. Beat selection is an indexed part-select; a separate beat mux is not worth a module.

Test Plan:
- Vector, no stall:
  - Stimulus: rst 2 cycles, then in_result=1234567890ABCDEF repeated 4x, in_flags=64'h0000_0000_0000_00A5, in_rd=5, in_scalar=0, wr_ready=1.
  - Required: wr_data=90ABCDEF... per beat 0..3 at N+1..N+4, all with wr_addr=5; done at N+5; flags_q=64'hA5.
- Scalar:
  - Stimulus: same result, in_scalar=1, in_rd=2.
  - Required: single beat at N+1 (wr_beat=0, wr_data=64'h1234_5678_90AB_CDEF, wr_addr=2); done at N+2; beats 1..3 never driven.
- Backpressure:
  - Stimulus: wr_ready=0 for 3 cycles during beat 1.
  - Required: wr_beat=1 and wr_data held constant; in_ready=0 throughout; done delayed by exactly 3 cycles (N+8).
- Back-to-back:
  - Stimulus: in_valid held high with two ops.
  - Required: second accept in the cycle done=1; 5-cycle spacing between first beats.
- Reset mid-transfer:
  - Stimulus: rst during beat 2.
  - Required: next cycle wr_en=0, in_ready=1, flags_q=0, no done pulse; a following op completes normally.
- Ignore while busy:
  - Stimulus: in_valid pulsed with rd=7 during SEND.
  - Required: not accepted; wr_addr stays at the original rd; only one done per accepted op.
